// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: time-multiplexed NUM_DIGITS hex display driver with shadow load, dp, leading-zero blanking and anti-ghost blank.
// Ports: clk, resetn (sync active-low); data (hex nibbles, digit 0 in [3:0]), dp_in (per-digit dp), load (capture shadow),
// blank_lz (leading-zero suppression), enable (0 = dark); seg_out (active-low, bit7 = dp), digit_sel (one-hot select), digit_idx (current slot).
module seven_seg_mux_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 2,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [IW-1:0]           digit_idx
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] OFF = ANODE_ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    typedef enum logic {BLANK, DISPLAY} state_t;
    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx_n;
    logic [7:0]              seg_n, pattern;
    logic [NUM_DIGITS-1:0]   sel_n, sel_on, sup;
    logic [4*NUM_DIGITS-1:0] sh_data;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    z;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_data <= '0;
            sh_dp   <= '0;
        end else if (load) begin
            sh_data <= data;
            sh_dp   <= dp_in;
        end
    end
    // sup[i]: every nibble from the top down to i is zero; digit 0 is never suppressed
    always_comb begin
        z   = 1'b1;
        sup = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z      = z & (sh_data[i*4 +: 4] == 4'h0);
            sup[i] = z;
        end
    end
    assign pattern = {~sh_dp[digit_idx], (blank_lz && sup[digit_idx]) ? 7'h7F : GLYPH[sh_data[digit_idx*4 +: 4]]};
    assign sel_on  = ANODE_ACTIVE_LOW != 0 ? ~(NUM_DIGITS'(1) << digit_idx) : NUM_DIGITS'(1) << digit_idx;
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = digit_idx;
        seg_n   = seg_out;
        sel_n   = digit_sel;
        if (!enable) begin
            state_n = BLANK;
            cnt_n   = '0;
            seg_n   = 8'hFF;
            sel_n   = OFF;
        end else if (state == BLANK) begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
                state_n = DISPLAY;
                seg_n   = pattern;
                sel_n   = sel_on;
            end
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            state_n = BLANK;
            cnt_n   = '0;
            seg_n   = 8'hFF;
            sel_n   = OFF;
            idx_n   = digit_idx == IW'(NUM_DIGITS - 1) ? '0 : digit_idx + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= BLANK;
            cnt       <= '0;
            digit_idx <= '0;
            seg_out   <= 8'hFF;
            digit_sel <= OFF;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            digit_idx <= idx_n;
            seg_out   <= seg_n;
            digit_sel <= sel_n;
        end
    end
endmodule
